fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined core: owns the fetch PC, issues one request at a time to instruction memory over a ready/valid handshake, and drives the IF/ID pipeline register consumed by Decode as `if_to_id_t` (`instruction`, `pc_cur`, `pc_plus_4`). Handles stall and flush from the hazard unit, redirects from Execute on taken branches and jumps, and discards in-flight responses made stale by a redirect.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0013` (`addi x0,x0,0`): the bubble encoding.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `stall_f`  in  1  hold the PC and the IF/ID register.
- `flush_d`  in  1  load a bubble into IF/ID.
- `pc_src_e`  in  1  redirect request from Execute.
- `pc_target_e`  in  32  redirect target address.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address; word aligned.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  32  response instruction word.
- `IF_to_ID`  out  `if_to_id_t`  registered IF/ID payload.
- `id_valid`  out  1  `IF_to_ID` holds a real instruction (0 means bubble).

## Operation
- Internal registers:
  - `pc_f`: next address to fetch.
  - `req_pc`: address of the outstanding request.
  - `kill`: the outstanding response is stale.
  - Hold buffer: one instruction and its PC.
- FSM states:
  - `S_BOOT`: reset state. `imem_req`=0. Goes to `S_REQ` on the first clock edge after reset is released.
  - `S_REQ`: `imem_req`=1, `imem_addr`=`pc_f`.
    - On `imem_ready`: `req_pc`<=`pc_f`, `pc_f`<=`pc_f`+4, go to `S_WAIT`.
    - `pc_src_e` without `imem_ready`: `pc_f`<=`pc_target_e`, stay in `S_REQ`. The address may change before acceptance.
    - `pc_src_e` together with `imem_ready`: the request is accepted but `kill`<=1, `pc_f`<=`pc_target_e`, go to `S_WAIT`.
  - `S_WAIT`: `imem_req`=0. Advances only on `imem_rvalid`:
    - `kill`=1: drop the response, clear `kill`, go to `S_REQ`.
    - `stall_f`=1: store the response in the hold buffer, go to `S_HOLD`.
    - Otherwise: deliver to IF/ID, go to `S_REQ`.
  - `pc_src_e` in `S_WAIT`: `pc_f`<=`pc_target_e`, `kill`<=1. If `imem_rvalid` arrives in the same cycle, the response is dropped and the FSM goes to `S_REQ`.
  - `S_HOLD`: `imem_req`=0.
    - On `!stall_f`: deliver the hold buffer, go to `S_REQ`.
    - On `pc_src_e`: discard the hold buffer, `pc_f`<=`pc_target_e`, go to `S_REQ`.
- IF/ID update priority, highest first:
  1. `flush_d`: instruction=`NOP_INSTR`, `pc_cur`=0, `pc_plus_4`=0, `id_valid`=0.
  2. `stall_f`: hold the current contents.
  3. Deliver: instruction=data, `pc_cur`=`req_pc`, `pc_plus_4`=`req_pc`+4, `id_valid`=1.
  4. Nothing deliverable: load a bubble.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC`+4 wraps to 0, with no error.
- `stall_f` does not block request acceptance in `S_REQ`. It only blocks delivery.

## Timing
- Reset values:
  - State `S_BOOT`, `pc_f`=`RESET_PC`, `kill`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `IF_to_ID`={`NOP_INSTR`, 0, 0}, `id_valid`=0.
- Reset asserted mid-transaction abandons the outstanding request. Any `imem_rvalid` seen in `S_BOOT` or `S_REQ` is ignored.
- Latency: acceptance at edge N and `imem_rvalid` in cycle N+k put the instruction on `IF_to_ID` after edge N+k.
- Throughput with zero-wait memory (ready always high, rvalid one cycle after acceptance): one instruction per 2 cycles.
- Redirect: the first request to `pc_target_e` is issued no later than the cycle after `pc_src_e`, or after the stale response returns if one is outstanding.
- No instruction from a pre-redirect address ever sets `id_valid`.

## Structure
- Add `fetch_state_t` (`S_BOOT`, `S_REQ`, `S_WAIT`, `S_HOLD`) to `types.svh`.
- Add the `NOP_INSTR` default constant to `params.svh`.
- `if_to_id_t` is unchanged.
- One natural sub-module: `if_id_reg`, the IF/ID register with flush/stall priority and `id_valid`. The FSM, PC, and hold buffer stay in `fetch_stage`.

## Test plan
- Reset release, memory always ready, rvalid 1 cycle after acceptance, rdata=addr: `IF_to_ID.pc_cur` = 0, 4, 8 on every second cycle; `pc_plus_4` = `pc_cur`+4; `id_valid`=1 on each delivery.
- Response arrives with `stall_f`=1 for 3 cycles: the hold buffer captures it and `IF_to_ID` is unchanged. The instruction appears on the edge after `stall_f` falls, and no request is issued meanwhile.
- `pc_src_e`=1 with `pc_target_e`=`32'h100` while in `S_WAIT` for `32'h8`: the `32'h8` response is dropped with `id_valid`=0. The next request address is `32'h100`, and the next delivered `pc_cur` is `32'h100`.
- `flush_d` and `stall_f` asserted together: `IF_to_ID`={`NOP_INSTR`, 0, 0}, `id_valid`=0.
- `pc_f`=`32'hFFFF_FFFC`, delivery: `pc_plus_4`=0 and the next request address is 0.
- `reset` asserted asynchronously mid-`S_WAIT`: outputs take their reset values immediately. A late `imem_rvalid` after release is ignored, and the first request address is `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_cur;
        logic [31:0] pc_plus_4;
    } if_to_id_t;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats delivery, idle loads a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        deliver,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output if_to_id_t   if_to_id,
    output logic        id_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_to_id <= '{instruction: NOP_INSTR, pc_cur: 32'd0, pc_plus_4: 32'd0};
            id_valid <= 1'b0;
        end else if (flush) begin
            if_to_id <= '{instruction: NOP_INSTR, pc_cur: 32'd0, pc_plus_4: 32'd0};
            id_valid <= 1'b0;
        end else if (stall) begin
            if_to_id <= if_to_id;
            id_valid <= id_valid;
        end else if (deliver) begin
            if_to_id <= '{instruction: instr, pc_cur: pc, pc_plus_4: pc + 32'd4};
            id_valid <= 1'b1;
        end else begin
            if_to_id <= '{instruction: NOP_INSTR, pc_cur: 32'd0, pc_plus_4: 32'd0};
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem request FSM, hold buffer,
// redirect handling with stale-response kill, feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output if_to_id_t   IF_to_ID,
    output logic        id_valid
);

    // Handshake: a request transfers on a cycle where imem_req && imem_ready; exactly one
    // response (imem_rvalid) follows per accepted request, and rvalid outside S_WAIT is ignored.

    fetch_state_t state, state_n;
    logic [31:0]  pc_f, pc_f_n;
    logic [31:0]  req_pc, req_pc_n;
    logic         kill, kill_n;
    logic [31:0]  hold_instr, hold_instr_n;
    logic [31:0]  hold_pc, hold_pc_n;
    logic         deliver;
    logic [31:0]  deliver_instr;
    logic [31:0]  deliver_pc;
    logic [31:0]  redirect_pc;

    assign redirect_pc = word_align(pc_target_e);
    assign imem_addr   = pc_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_BOOT;
            pc_f       <= RESET_PC;
            req_pc     <= RESET_PC;
            kill       <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= 32'd0;
        end else begin
            state      <= state_n;
            pc_f       <= pc_f_n;
            req_pc     <= req_pc_n;
            kill       <= kill_n;
            hold_instr <= hold_instr_n;
            hold_pc    <= hold_pc_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_f_n        = pc_f;
        req_pc_n      = req_pc;
        kill_n        = kill;
        hold_instr_n  = hold_instr;
        hold_pc_n     = hold_pc;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = req_pc;
        imem_req      = 1'b0;

        case (state)
            S_BOOT: state_n = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    req_pc_n = pc_f;
                    pc_f_n   = pc_f + 32'd4;
                    state_n  = S_WAIT;
                    if (pc_src_e) begin
                        kill_n = 1'b1;
                        pc_f_n = redirect_pc;
                    end
                end else if (pc_src_e) begin
                    pc_f_n = redirect_pc;
                end
            end
            S_WAIT: begin
                if (pc_src_e) pc_f_n = redirect_pc;
                if (imem_rvalid) begin
                    // A redirect in the response cycle drops it here, so kill never lingers.
                    state_n = S_REQ;
                    kill_n  = 1'b0;
                    if (!kill && !pc_src_e) begin
                        if (stall_f) begin
                            hold_instr_n = imem_rdata;
                            hold_pc_n    = req_pc;
                            state_n      = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (pc_src_e) begin
                    kill_n = 1'b1;
                end
            end
            S_HOLD: begin
                deliver_instr = hold_instr;
                deliver_pc    = hold_pc;
                if (pc_src_e) begin
                    pc_f_n  = redirect_pc;
                    state_n = S_REQ;
                end else if (!stall_f) begin
                    deliver = 1'b1;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_BOOT;
        endcase
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush_d),
        .stall   (stall_f),
        .deliver (deliver),
        .instr   (deliver_instr),
        .pc      (deliver_pc),
        .if_to_id(IF_to_ID),
        .id_valid(id_valid)
    );

endmodule
